// File: rtl/vec_result_writeback_if.sv
// Result/write-port bundle between the vector ALU, the writeback block and the
// register file: ALU valid/ready side plus the single-cycle write strobe side.
interface vec_result_writeback_if #(
    parameter int LANES  = 16,
    parameter int ELEM_W = 32,
    parameter int ADDR_W = 2
);
    logic                        in_valid;
    logic                        in_ready;
    logic [LANES*2*ELEM_W-1:0]   in_data;
    logic [ADDR_W-1:0]           in_dst_lo;
    logic [ADDR_W-1:0]           in_dst_hi;
    logic                        in_narrow;
    logic                        wr_en;
    logic [ADDR_W-1:0]           wr_addr;
    logic [LANES*ELEM_W-1:0]     wr_data;
    logic                        busy;
    logic                        done;

    modport master (
        output in_valid, in_data, in_dst_lo, in_dst_hi, in_narrow,
        input  in_ready, wr_en, wr_addr, wr_data, busy, done
    );

    modport slave (
        input  in_valid, in_data, in_dst_lo, in_dst_hi, in_narrow,
        output in_ready, wr_en, wr_addr, wr_data, busy, done
    );
endinterface

// File: rtl/vec_result_writeback.sv
// Narrows a 16x64-bit ALU result onto the 512-bit register write port in two writes.
// Optional VWB_SATURATE_NARROW_EN: in_narrow selects a single saturating write.
module vec_result_writeback #(
    parameter int LANES  = 16,
    parameter int ELEM_W = 32,
    parameter int ADDR_W = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    vec_result_writeback_if.slave bus
);
    localparam int LW = 2 * ELEM_W;
    localparam int DW = LANES * ELEM_W;

    typedef enum logic [1:0] {
        IDLE,
        WR_LO,
        WR_HI
    } state_t;

    state_t state, state_nx;

    logic              accept;
    logic              narrow_in;
    logic [DW-1:0]     lo_words;
    logic [DW-1:0]     hi_words;
    logic [DW-1:0]     sat_words;

    logic [DW-1:0]     cap_hi;
    logic [ADDR_W-1:0] cap_dst_hi;
    logic              cap_narrow;

    logic              wr_en_q,   wr_en_nx;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_nx;
    logic [DW-1:0]     wr_data_q, wr_data_nx;
    logic              done_q,    done_nx;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic [LW-1:0] lane;
        assign lane = bus.in_data[g*LW +: LW];
        assign lo_words[g*ELEM_W +: ELEM_W] = lane[ELEM_W-1:0];
        assign hi_words[g*ELEM_W +: ELEM_W] = lane[LW-1:ELEM_W];
`ifdef VWB_SATURATE_NARROW_EN
        // In range only when the top 33 bits are all copies of the sign.
        logic in_range;
        assign in_range = (&lane[LW-1:ELEM_W-1]) | ~(|lane[LW-1:ELEM_W-1]);
        assign sat_words[g*ELEM_W +: ELEM_W] =
            in_range  ? lane[ELEM_W-1:0] :
            lane[LW-1] ? {1'b1, {(ELEM_W-1){1'b0}}} :
                         {1'b0, {(ELEM_W-1){1'b1}}};
`else
        assign sat_words[g*ELEM_W +: ELEM_W] = lane[ELEM_W-1:0];
`endif
    end

`ifdef VWB_SATURATE_NARROW_EN
    assign narrow_in = bus.in_narrow;
`else
    logic unused_narrow;
    assign unused_narrow = bus.in_narrow;
    assign narrow_in     = 1'b0;
`endif

    assign bus.in_ready = (state == IDLE) || (state == WR_HI);
    assign accept       = bus.in_valid && bus.in_ready;

    always_comb begin
        state_nx   = state;
        wr_en_nx   = 1'b0;
        wr_addr_nx = wr_addr_q;
        wr_data_nx = wr_data_q;
        done_nx    = 1'b0;
        unique case (state)
            IDLE:    if (accept) state_nx = WR_LO;
            WR_LO:   state_nx = cap_narrow ? IDLE : WR_HI;
            WR_HI:   state_nx = accept ? WR_LO : IDLE;
            default: state_nx = IDLE;
        endcase
        // Outputs are loaded one edge early so they line up with the state.
        if (accept) begin
            wr_en_nx   = 1'b1;
            wr_addr_nx = bus.in_dst_lo;
            wr_data_nx = narrow_in ? sat_words : lo_words;
            done_nx    = narrow_in;
        end else if (state == WR_LO && !cap_narrow) begin
            wr_en_nx   = 1'b1;
            wr_addr_nx = cap_dst_hi;
            wr_data_nx = cap_hi;
            done_nx    = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cap_hi     <= '0;
            cap_dst_hi <= '0;
            cap_narrow <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            done_q     <= 1'b0;
        end else begin
            state     <= state_nx;
            wr_en_q   <= wr_en_nx;
            wr_addr_q <= wr_addr_nx;
            wr_data_q <= wr_data_nx;
            done_q    <= done_nx;
            if (accept) begin
                cap_hi     <= hi_words;
                cap_dst_hi <= bus.in_dst_hi;
                cap_narrow <= narrow_in;
            end
        end
    end

    assign bus.wr_en   = wr_en_q;
    assign bus.wr_addr = wr_addr_q;
    assign bus.wr_data = wr_data_q;
    assign bus.done    = done_q;
    assign bus.busy    = (state != IDLE);
endmodule

// File: tb/tb_vec_result_writeback.sv
// Randomized bench for vec_result_writeback against a write-schedule model.
// Macro VWB_SATURATE_NARROW_EN selects the saturating model as in the design.
module tb_vec_result_writeback;
    localparam int LANES  = 16;
    localparam int ELEM_W = 32;
    localparam int ADDR_W = 2;
    localparam int DW     = LANES * ELEM_W;
    localparam int IW     = 2 * DW;

    typedef struct {
        bit                lo;
        bit                last;
        logic [ADDR_W-1:0] addr;
        logic [DW-1:0]     data;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vec_result_writeback_if #(
        .LANES(LANES), .ELEM_W(ELEM_W), .ADDR_W(ADDR_W)
    ) bus ();

    vec_result_writeback #(
        .LANES(LANES), .ELEM_W(ELEM_W), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int            checks = 0;
    int            errors = 0;
    wr_t           sched[$];
    bit            exp_ready = 1'b1;
    logic [DW-1:0] last_data = '0;

    task automatic check(string tag, logic [DW-1:0] got, logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] sat32(logic [63:0] v);
        longint s;
        s = v;
        if (s > 64'sd2147483647)  return 32'h7FFF_FFFF;
        if (s < -64'sd2147483648) return 32'h8000_0000;
        return v[31:0];
    endfunction

    // Model: each accepted result becomes a list of writes, one per cycle.
    task automatic push(logic [IW-1:0] d, logic [ADDR_W-1:0] lo,
                        logic [ADDR_W-1:0] hi, bit narrow);
        wr_t a, b;
        a.lo = 1; a.last = 0; a.addr = lo;
        b.lo = 0; b.last = 1; b.addr = hi;
        for (int i = 0; i < LANES; i++) begin
            a.data[i*32 +: 32] = d[i*64 +: 32];
            b.data[i*32 +: 32] = d[i*64+32 +: 32];
        end
`ifdef VWB_SATURATE_NARROW_EN
        if (narrow) begin
            for (int i = 0; i < LANES; i++)
                a.data[i*32 +: 32] = sat32(d[i*64 +: 64]);
            a.last = 1;
            sched.push_back(a);
            return;
        end
`else
        if (narrow) a.last = 0;
`endif
        sched.push_back(a);
        sched.push_back(b);
    endtask

    task automatic drive(bit v, logic [IW-1:0] d, logic [ADDR_W-1:0] lo,
                         logic [ADDR_W-1:0] hi, bit narrow);
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.in_dst_lo = lo;
        bus.in_dst_hi = hi;
        bus.in_narrow = narrow;
        if (v && exp_ready) push(d, lo, hi, narrow);
    endtask

    task automatic tick_check();
        wr_t cur;
        bit  have;
        @(posedge clk);
        #1;
        have = sched.size() > 0;
        if (have) cur = sched.pop_front();
        check("wr_en", DW'(bus.wr_en), DW'(have));
        check("busy", DW'(bus.busy), DW'(have));
        check("done", DW'(bus.done), DW'(have && cur.last));
        check("in_ready", DW'(bus.in_ready), DW'(!(have && cur.lo)));
        if (have) begin
            check("wr_addr", DW'(bus.wr_addr), DW'(cur.addr));
            last_data = cur.data;
        end
        check("wr_data", bus.wr_data, last_data);
        exp_ready = !(have && cur.lo);
    endtask

    function automatic logic [IW-1:0] fill(logic [63:0] lane);
        logic [IW-1:0] d;
        for (int i = 0; i < LANES; i++) d[i*64 +: 64] = lane;
        return d;
    endfunction

    function automatic logic [IW-1:0] rand_data();
        logic [IW-1:0] d;
        logic [31:0]   r;
        for (int i = 0; i < LANES; i++) begin
            r = $urandom;
            case ($urandom_range(0, 3))
                0: d[i*64 +: 64] = {$urandom, r};
                1: d[i*64 +: 64] = {{32{r[31]}}, r};
                2: d[i*64 +: 64] = {32'h0, 1'b1, r[30:0]};
                default: d[i*64 +: 64] = {{31{r[0]}}, ~r[0], r};
            endcase
        end
        return d;
    endfunction

    logic [IW-1:0] da, db;

    initial begin
        drive(0, '0, '0, '0, 0);
        tick_check();
        tick_check();
        #2 rst = 1'b0;
        tick_check();

        // single result, split into low then high words
        drive(1, fill(64'h0000_0001_FFFF_FFFE), 2'd1, 2'd2, 0);
        tick_check();
        drive(0, '0, '0, '0, 0);
        repeat (3) tick_check();

        // back-to-back with in_valid held
        da = rand_data();
        db = rand_data();
        drive(1, da, 2'd0, 2'd1, 0);
        tick_check();
        drive(1, db, 2'd2, 2'd3, 0);
        tick_check();
        drive(1, db, 2'd2, 2'd3, 0);
        tick_check();
        drive(0, '0, '0, '0, 0);
        repeat (3) tick_check();

        // equal destinations
        da = rand_data();
        da[63:0] = 64'h0000_0005_0000_0007;
        drive(1, da, 2'd3, 2'd3, 0);
        tick_check();
        drive(0, '0, '0, '0, 0);
        repeat (3) tick_check();

        // narrow request (saturating only when the feature is built in)
        da = '0;
        da[63:0]    = 64'sd5;
        da[127:64]  = 64'h0000_0001_0000_0000;
        da[191:128] = 64'hFFFF_FFFE_0000_0000;
        drive(1, da, 2'd1, 2'd2, 1);
        tick_check();
        drive(0, '0, '0, '0, 0);
        repeat (3) tick_check();

        // async reset while the low write is on the port
        drive(1, rand_data(), 2'd0, 2'd1, 0);
        tick_check();
        drive(0, '0, '0, '0, 0);
        #2 rst = 1'b1;
        #1;
        check("rst_wr_en", DW'(bus.wr_en), '0);
        check("rst_busy", DW'(bus.busy), '0);
        check("rst_done", DW'(bus.done), '0);
        check("rst_wr_data", bus.wr_data, '0);
        check("rst_in_ready", DW'(bus.in_ready), DW'(1));
        sched.delete();
        last_data = '0;
        exp_ready = 1'b1;
        tick_check();
        #2 rst = 1'b0;
        drive(1, rand_data(), 2'd2, 2'd1, 0);
        tick_check();
        drive(0, '0, '0, '0, 0);
        repeat (3) tick_check();

        // random traffic
        repeat (400) begin
            drive($urandom_range(0, 3) != 0, rand_data(),
                  ADDR_W'($urandom), ADDR_W'($urandom),
                  $urandom_range(0, 2) == 0);
            tick_check();
        end
        drive(0, '0, '0, '0, 0);
        repeat (4) tick_check();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/vec_result_writeback.md
Name: vec_result_writeback

Overview:
- Receives one 1024-bit wide result vector (16 lanes × 64-bit products/sums) from the vector ALU.
- Narrows it back onto the 512-bit vector register file write port: low words in one write, high words in a second write.
- Sits between the ALU output and the register file write port.
- Valid/ready on the ALU side, single-cycle write strobes on the register side.

Parameters:
- LANES, 16, number of vector lanes.
- ELEM_W, 32, register element width; ALU lane width is 2*ELEM_W.
- ADDR_W, 2, register file index width.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  result vector valid.
- in_ready  out  1  block can accept a result this cycle.
- in_data  in  LANES*2*ELEM_W (1024)  ALU result; lane i at bits [i*64 +: 64].
- in_dst_lo  in  ADDR_W  destination register for low words.
- in_dst_hi  in  ADDR_W  destination register for high words.
- in_narrow  in  1  saturating single-write mode (see Optional Feature).
- wr_en  out  1  register file write strobe.
- wr_addr  out  ADDR_W  register file write index.
- wr_data  out  LANES*ELEM_W (512)  register file write data.
- busy  out  1  a captured result is not fully written.
- done  out  1  one-cycle pulse in the cycle of the final write of a result.

Behaviour:
- States: IDLE, WR_LO, WR_HI.
- Reset values: state=IDLE; wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, capture registers=0. in_ready=1 while rst is deasserted in IDLE.
- in_ready = (state==IDLE) || (state==WR_HI). Purely from state, never from in_valid.
- Accept = in_valid && in_ready. On accept:
  - Latch in_data, in_dst_lo, in_dst_hi and in_narrow.
  - Next state = WR_LO.
- WR_LO:
  - wr_en=1, wr_addr=dst_lo.
  - wr_data lane i = captured lane i bits [31:0].
  - Next state = WR_HI, or IDLE if narrow.
- WR_HI:
  - wr_en=1, wr_addr=dst_hi.
  - wr_data lane i = captured lane i bits [63:32].
  - done=1.
  - Next state = WR_LO if a new accept occurs this cycle, else IDLE.
- Write outputs are registered from state and capture registers only. In IDLE: wr_en=0 and wr_data holds its last value.
- Latency: accept at cycle N → low write at N+1, high write at N+2.
- Sustained throughput is one result per 2 cycles, with no bubble between back-to-back results.
- busy=1 in WR_LO and WR_HI.
- Equal destinations (dst_lo==dst_hi): both writes are issued in order, so the high write is the final register content.
- in_data is sampled only on accept. Changes while busy have no effect.
- in_valid is held with in_ready=0 (in WR_LO): no capture, no data loss; the result is accepted in the following WR_HI.
- Asynchronous rst mid-operation: state=IDLE and wr_en=0 immediately. The pending result is discarded and no done pulse is issued.

Optional Feature:
- Macro VWB_SATURATE_NARROW_EN.
- Defined:
  - in_narrow=1 at accept selects saturating narrow mode.
  - Each 64-bit signed lane is clamped to [-2^31, 2^31-1] and written as one word in a single WR_LO write to dst_lo.
  - done pulses in that WR_LO cycle; the next state is IDLE.
  - in_ready is 0 during that WR_LO.
- Not defined: in_narrow is ignored (treated as 0) and every result takes two writes.

Test Plan:
- Reset then idle → wr_en=0, busy=0, done=0, in_ready=1. Assert rst asynchronously mid-clock → outputs clear without waiting for a clock edge.
- Single result, every lane = 64'h0000_0001_FFFF_FFFE, dst_lo=1, dst_hi=2 → cycle N+1: wr_addr=1, all words 32'hFFFF_FFFE. Cycle N+2: wr_addr=2, all words 32'h0000_0001, done=1.
- Back-to-back results A then B with in_valid held high → write sequence A_lo, A_hi, B_lo, B_hi on consecutive cycles. in_ready pattern 1,0,1,0. Two done pulses.
- dst_lo=dst_hi=3, lane0=64'h0000_0005_0000_0007 → two writes to reg 3 with words 7 then 5.
- rst asserted during WR_LO → no WR_HI write, no done. The next accepted result writes normally.
- With VWB_SATURATE_NARROW_EN and in_narrow=1:
  - Lanes 64'sd5, 64'h0000_0001_0000_0000 and 64'hFFFF_FFFE_0000_0000 → words 5, 32'h7FFF_FFFF and 32'h8000_0000.
  - Single write to dst_lo, with done in the same cycle.
- Same stimulus without the macro → normal two-write split.
